// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-bank write-port arbiter: write-back vs debug, forced stall after MAX_WAIT collisions
// Optional ARB_STATS_EN adds o_stall_count (forced-stall cycles, saturating).
module regfile_write_arbiter #(
    parameter int len                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int MAX_WAIT             = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_wb_regwrite,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_wb_reg,
    input  logic [len-1:0]                  i_wb_data,
    input  logic                            i_dbg_req,
    output logic                            o_dbg_ready,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_dbg_reg,
    input  logic [len-1:0]                  i_dbg_data,
    output logic                            o_dbg_done,
    output logic                            o_stall_req,
    output logic                            o_we,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_waddr,
    output logic [len-1:0]                  o_wdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]                     o_stall_count
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;

    state_t                            state_q, state_d;
    logic [7:0]                        wait_cnt_q, wait_cnt_d;
    logic [NB_ADDRESS_REGISTROS-1:0]   dbg_reg_q, dbg_reg_d;
    logic [len-1:0]                    dbg_data_q, dbg_data_d;
    logic                              we_q, we_d;
    logic [NB_ADDRESS_REGISTROS-1:0]   waddr_q, waddr_d;
    logic [len-1:0]                    wdata_q, wdata_d;
    logic                              done_q, done_d;
    logic                              accept, sel_wb, sel_dbg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            dbg_reg_q  <= '0;
            dbg_data_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            dbg_reg_q  <= dbg_reg_d;
            dbg_data_q <= dbg_data_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    assign accept = i_dbg_req & o_dbg_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dbg_reg_d  = dbg_reg_q;
        dbg_data_d = dbg_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dbg_reg_d  = i_dbg_reg;
                    dbg_data_d = i_dbg_data;
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_wb_regwrite) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_q == 8'(MAX_WAIT - 1)) state_d = ST_FORCE;
                end
            end
            ST_FORCE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Stall is combinational from state so the pipeline holds in the very cycle debug owns the port.
    always_comb begin
        o_dbg_ready = (state_q == ST_IDLE);
        o_stall_req = (state_q == ST_FORCE);
        sel_dbg     = (state_q == ST_FORCE) || ((state_q == ST_WAIT) && !i_wb_regwrite);
        sel_wb      = (state_q != ST_FORCE) && i_wb_regwrite;
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        if (sel_dbg) begin
            we_d    = (dbg_reg_q != '0);
            waddr_d = dbg_reg_q;
            wdata_d = dbg_data_q;
            done_d  = 1'b1;
        end else if (sel_wb) begin
            we_d    = (i_wb_reg != '0);
            waddr_d = i_wb_reg;
            wdata_d = i_wb_data;
        end
    end

    assign o_we       = we_q;
    assign o_waddr    = waddr_q;
    assign o_wdata    = wdata_q;
    assign o_dbg_done = done_q;

`ifdef ARB_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (state_q == ST_FORCE && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) stall_count_q <= '0;
        else         stall_count_q <= stall_count_d;
    end

    assign o_stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst, wbw, dq;
    logic [4:0]  wbr, dr;
    logic [31:0] wbd, dd;
    logic        ready, done, stall, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef ARB_STATS_EN
    logic [15:0] stall_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.len(32), .NB_ADDRESS_REGISTROS(5), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_regwrite(wbw), .i_wb_reg(wbr), .i_wb_data(wbd),
        .i_dbg_req(dq), .o_dbg_ready(ready), .i_dbg_reg(dr), .i_dbg_data(dd),
        .o_dbg_done(done), .o_stall_req(stall),
        .o_we(we), .o_waddr(waddr), .o_wdata(wdata)
`ifdef ARB_STATS_EN
        , .o_stall_count(stall_count)
`endif
    );

    typedef struct {
        logic rst, wbw; logic [4:0] wbr; logic [31:0] wbd;
        logic dq; logic [4:0] dr; logic [31:0] dd;
        logic e_we; logic [4:0] e_addr; logic [31:0] e_data;
        logic e_done, e_stall, e_ready, chk_ad;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] wr, input logic [31:0] wd,
                         input logic q, input logic [4:0] qr, input logic [31:0] qd);
        rst = r; wbw = w; wbr = wr; wbd = wd; dq = q; dr = qr; dd = qd;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string nm, input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
                           input logic e_done, input logic e_stall, input logic e_ready, input logic chk_ad);
        chk({nm, ".we"}, 32'(we), 32'(e_we));
        chk({nm, ".done"}, 32'(done), 32'(e_done));
        chk({nm, ".stall"}, 32'(stall), 32'(e_stall));
        chk({nm, ".ready"}, 32'(ready), 32'(e_ready));
        if (chk_ad) begin
            chk({nm, ".waddr"}, 32'(waddr), 32'(e_addr));
            chk({nm, ".wdata"}, wdata, e_data);
        end
    endtask

    // Reference model: a pending debug write, a count of WB collisions against it, and a stall flag.
    logic        m_pend, m_stall, m_we, m_done;
    logic [4:0]  m_preg, m_addr;
    logic [31:0] m_pdata, m_data;
    int          m_coll, m_stalls;

    task automatic m_commit(input logic [4:0] r, input logic [31:0] d, input logic is_dbg);
        m_we = (r != 5'd0); m_addr = r; m_data = d; m_done = is_dbg;
    endtask

    task automatic model_edge();
        m_we = 1'b0; m_done = 1'b0;
        if (rst) begin
            m_pend = 0; m_stall = 0; m_coll = 0; m_stalls = 0; m_addr = 0; m_data = 0;
        end else if (m_stall) begin
            m_commit(m_preg, m_pdata, 1'b1);
            m_pend = 0; m_stall = 0;
            if (m_stalls < 65535) m_stalls++;
        end else if (m_pend) begin
            if (wbw) begin
                m_commit(wbr, wbd, 1'b0);
                m_coll++;
                if (m_coll == MAX_WAIT) m_stall = 1;
            end else begin
                m_commit(m_preg, m_pdata, 1'b1);
                m_pend = 0;
            end
        end else begin
            if (wbw) m_commit(wbr, wbd, 1'b0);
            if (dq) begin
                m_pend = 1; m_preg = dr; m_pdata = dd; m_coll = 0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 5'd5, 32'h10, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h10,       1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h55,       1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'hAA,       1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'hAA,       1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};

        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rst, vecs[i].wbw, vecs[i].wbr, vecs[i].wbd, vecs[i].dq, vecs[i].dr, vecs[i].dd);
            cyc();
            chk_all($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                    vecs[i].e_done, vecs[i].e_stall, vecs[i].e_ready, vecs[i].chk_ad);
        end

        // Forced stall: debug accepted with WB idle, then WB every cycle
        drive(1, 0, 0, 0, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 1, 5'd9, 32'h900); cyc();
        chk_all("force.acc", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < MAX_WAIT; k++) begin
            drive(0, 1, 5'(7 + k), 32'(32'h70 + k), 0, 0, 0); cyc();
            chk_all($sformatf("force.wb%0d", k), 1, 5'(7 + k), 32'(32'h70 + k), 0, (k == MAX_WAIT - 1), 0, 1);
        end
        drive(0, 1, 5'd11, 32'h74, 0, 0, 0); cyc();
        chk_all("force.dbg", 1, 5'd9, 32'h900, 1, 0, 1, 1);
        drive(0, 1, 5'd11, 32'h74, 0, 0, 0); cyc();
        chk_all("force.held", 1, 5'd11, 32'h74, 0, 0, 1, 1);
`ifdef ARB_STATS_EN
        chk("force.stall_count", 32'(stall_count), 32'd1);
`endif

        // Reset while debug write is waiting
        drive(0, 1, 5'd4, 32'h40, 1, 5'd6, 32'h600); cyc();
        chk_all("rstw.acc", 1, 5'd4, 32'h40, 0, 0, 0, 1);
        drive(0, 1, 5'd5, 32'h50, 0, 0, 0); cyc();
        drive(1, 1, 5'd5, 32'h50, 0, 0, 0); cyc();
        chk_all("rstw.rst", 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0); cyc();
        chk_all("rstw.after", 0, 0, 0, 0, 0, 1, 0);
`ifdef ARB_STATS_EN
        chk("rstw.stall_count", 32'(stall_count), 32'd0);
`endif

        // Randomized run against the reference model
        drive(1, 0, 0, 0, 0, 0, 0);
        model_edge(); cyc();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < (i < 1500 ? 88 : 40)),
                  5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 31)), $urandom);
            model_edge();
            cyc();
            chk_all($sformatf("rand%0d", i), m_we, m_addr, m_data, m_done, m_stall, !m_pend, (m_we | m_done));
`ifdef ARB_STATS_EN
            chk($sformatf("rand%0d.stall_count", i), 32'(stall_count), 32'(m_stalls));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
